fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  PC sequencer and fetch controller for the word-indexed instruction ROM (programMem). Drives the ROM's
//  pc input, registers the returned word, and issues it downstream on a valid/ready handshake.
//  Supports start-at-address, branch redirect, HALT detection (all-zero word) and out-of-range fault.
//  Sits between top-level test control and the decode stage of the single-issue core.
// PARAMETERS
//  PC_W       32     width of pc / start_pc / redirect_pc
//  MEM_DEPTH  32     number of ROM words; legal pc range 0..MEM_DEPTH-1
//  HALT_WORD  32'h0  instruction encoding treated as HALT
// PORTS
//  clk            in   1     single clock, rising edge
//  reset          in   1     asynchronous, active-high reset
//  start          in   1     begin fetching at start_pc; honoured in IDLE, HALTED, FAULT only
//  start_pc       in   PC_W  first word index
//  pc             out  PC_W  word index to ROM (ROM returns mem_instr combinationally, same cycle)
//  mem_instr      in   32    ROM read data for pc
//  instr_out      out  32    registered instruction to decode
//  instr_valid    out  1     instr_out holds an unconsumed word
//  instr_ready    in   1     decode accepts instr_out when instr_valid && instr_ready
//  redirect_valid in   1     branch/jump redirect, honoured in RUN only
//  redirect_pc    in   PC_W  redirect target word index
//  busy           out  1     state == RUN
//  halted         out  1     state == HALTED
//  fault          out  1     state == FAULT
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, instr_out=0, instr_valid=0; busy/halted/fault=0 (all decoded from state).
//  States: IDLE, RUN, HALTED, FAULT.
//  IDLE/HALTED/FAULT + start: pc<=start_pc, instr_valid<=0; start_pc>=MEM_DEPTH -> FAULT, else RUN.
//  RUN, "advance" = !instr_valid || instr_ready (output slot free or being freed this cycle):
//   - redirect_valid (highest priority): pc<=redirect_pc, instr_valid<=0 regardless of instr_ready
//     (held word is wrong-path, dropped); redirect_pc>=MEM_DEPTH -> FAULT.
//   - else advance && mem_instr==HALT_WORD: instr_out<=mem_instr, instr_valid<=1, pc held -> HALTED.
//   - else advance: instr_out<=mem_instr, instr_valid<=1; pc+1==MEM_DEPTH -> FAULT (word still
//     issued), else pc<=pc+1.
//   - else (stalled): pc, instr_out, instr_valid held.
//  HALTED/FAULT: the last issued word stays valid until handshaken, then instr_valid<=0; no new fetches;
//   redirect ignored.
//  start while in RUN ignored. Redirect and start never both honoured (disjoint states).
//  Latency: start at edge N -> pc=start_pc after N; instr_valid=1 with ROM[start_pc] after N+1;
//   thereafter one word per cycle with instr_ready held high.
//  pc comparisons are unsigned at full PC_W; no wrap to 0 ever occurs.
//  Reset mid-operation: immediate return to reset values; in-flight word discarded.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_issued[31:0] (count of instr_valid&&instr_ready
//   handshakes) and perf_stalls[31:0] (cycles with instr_valid&&!instr_ready); both reset to 0 and
//   cleared on an honoured start; saturate at 32'hFFFF_FFFF.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  Reset asserted mid-RUN -> next cycle pc=0, instr_valid=0, busy/halted/fault=0.
//  start, start_pc=0, instr_ready=1, ROM test 1 -> words 0..7 issued in order on consecutive cycles,
//   halt word issued last, halted=1, pc=7.
//  start_pc=8, instr_ready low for 3 cycles after first word -> instr_out=ROM[8] and pc=9 held 3 cycles;
//   then words 9..19 issued, halted=1 with pc=19.
//  start_pc=8, redirect_valid with redirect_pc=14 while ROM[11] held unaccepted -> ROM[11] never
//   handshaken; next issued word ROM[14]; pc=15 the following cycle.
//  start_pc=40 -> fault=1 next cycle, instr_valid stays 0; then start, start_pc=0 -> fault=0, RUN.
//  start_pc=30 with ROM[30..31] non-halt -> both words issued, fault=1, pc=31, no further fetch.
//  FETCH_PERF_CNT_EN with the backpressure test: perf_issued=12, perf_stalls=3 at HALTED.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencer and fetch controller for the word-indexed instruction ROM.
// Drives the ROM pc, registers the returned word and issues it on a valid/ready handshake.
// Ports: clk, reset (async, active-high), start/start_pc (begin fetch), pc/mem_instr (ROM side),
//        instr_out/instr_valid/instr_ready (decode side), redirect_valid/redirect_pc (branch),
//        busy/halted/fault (state flags).
// Optional macro FETCH_PERF_CNT_EN adds perf_issued/perf_stalls saturating counters.
module fetch_sequencer #(
    parameter int          PC_W      = 32,
    parameter int          MEM_DEPTH = 32,
    parameter logic [31:0] HALT_WORD = 32'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    output logic [PC_W-1:0] pc,
    input  logic [31:0]     mem_instr,
    output logic [31:0]     instr_out,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            busy,
    output logic            halted,
    output logic            fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stalls
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED,
        S_FAULT
    } state_t;

    // One extra bit so pc+1 and range checks never wrap.
    localparam logic [PC_W:0] DEPTH_X = (PC_W+1)'(MEM_DEPTH);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;

    logic            hs;
    logic            advance;
    logic            start_ok;
    logic [PC_W:0]   pc_inc;

    assign hs      = valid_q && instr_ready;
    assign advance = !valid_q || instr_ready;
    assign pc_inc  = {1'b0, pc_q} + 1'b1;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        start_ok = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (redirect_valid) begin
                    // Held word is wrong-path: drop it even if decode takes it now.
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    if ({1'b0, redirect_pc} >= DEPTH_X) begin
                        state_d = S_FAULT;
                    end
                end else if (advance) begin
                    instr_d = mem_instr;
                    valid_d = 1'b1;
                    if (mem_instr == HALT_WORD) begin
                        state_d = S_HALTED;
                    end else if (pc_inc == DEPTH_X) begin
                        // Last legal word still issues; pc stays on it.
                        state_d = S_FAULT;
                    end else begin
                        pc_d = pc_inc[PC_W-1:0];
                    end
                end
            end
            S_IDLE, S_HALTED, S_FAULT: begin
                if (hs) begin
                    valid_d = 1'b0;
                end
                if (start) begin
                    start_ok = 1'b1;
                    pc_d     = start_pc;
                    valid_d  = 1'b0;
                    if ({1'b0, start_pc} >= DEPTH_X) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc          = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign busy        = (state_q == S_RUN);
    assign halted      = (state_q == S_HALTED);
    assign fault       = (state_q == S_FAULT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] issued_q, issued_d;
    logic [31:0] stalls_q, stalls_d;

    always_comb begin
        issued_d = issued_q;
        stalls_d = stalls_q;
        if (start_ok) begin
            issued_d = '0;
            stalls_d = '0;
        end else begin
            if (hs && issued_q != 32'hFFFF_FFFF) begin
                issued_d = issued_q + 32'd1;
            end
            if (valid_q && !instr_ready && stalls_q != 32'hFFFF_FFFF) begin
                stalls_d = stalls_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued_q <= '0;
            stalls_q <= '0;
        end else begin
            issued_q <= issued_d;
            stalls_q <= stalls_d;
        end
    end

    assign perf_issued = issued_q;
    assign perf_stalls = stalls_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule
